// File: rtl/counter_pkg.sv
// Shared definitions for the COUNTER library: direction encodings and
// the elaboration-time parameter legality check.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int unsigned MAX_WIDTH = 16;

    // True when WIDTH, MODULUS and RESET_VAL describe a buildable counter.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned modulus,
                                     input int unsigned reset_val);
        bit ok;
        ok = (width >= 1) && (width <= MAX_WIDTH);
        ok = ok && (modulus >= 2) && (modulus <= (32'd1 << width));
        ok = ok && (reset_val < modulus);
        return ok;
    endfunction

endpackage

// File: rtl/t_ff_sync_ld.sv
// Single-bit T flip-flop with synchronous reset to a per-bit value and a
// synchronous parallel-load path.
module t_ff_sync_ld (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/updown_count_mod_t_ff.sv
// Parametrised synchronous up/down modulo counter built from T flip-flop
// cells, with parallel load, cascadable terminal count and sticky wrap flag.
module updown_count_mod_t_ff
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wrap_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_param_check
        $error("updown_count_mod_t_ff: illegal WIDTH/MODULUS/RESET_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic             count_up;
    logic             at_wrap;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] toggle;

    assign count_up = (up_dn == CNT_UP);
    assign at_wrap  = count_up ? (q == MAX_Q) : (q == '0);
    assign tc       = en & ~load & ~rst & at_wrap;

    // Out-of-range load values saturate to the top of the count range.
    assign ld_data = ({1'b0, load_val} >= MOD_EXT) ? MAX_Q : load_val;

    // Ripple-free toggle decode: a bit flips when every lower bit sits at the
    // carry/borrow value; at the wrap point the cells jump straight to target.
    always_comb begin
        logic run;
        toggle = '0;
        run    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = run;
            run       = run & (count_up ? q[i] : ~q[i]);
        end
        if (at_wrap) begin
            toggle = q ^ (count_up ? {WIDTH{1'b0}} : MAX_Q);
        end
        if (!en) begin
            toggle = '0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_sync_ld u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_Q[i]),
            .ld      (load),
            .d       (ld_data[i]),
            .t       (toggle[i]),
            .q       (q[i])
        );
    end

    // A wrap in the same cycle as a clear must win so the event is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrapped <= 1'b0;
        end else if (tc) begin
            wrapped <= 1'b1;
        end else if (wrap_clr) begin
            wrapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_count_mod_t_ff.sv
// Directed bench for updown_count_mod_t_ff: a mod-10 instance driven from a
// vector table, plus two default instances cascaded as an 8-bit down counter.
module tb_updown_count_mod_t_ff;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       wrap_clr;
    logic [3:0] q;
    logic       tc;
    logic       wrapped;

    logic       casc_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrapped, hi_wrapped;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_count_mod_t_ff #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .wrap_clr(wrap_clr),
        .q(q), .tc(tc), .wrapped(wrapped)
    );

    updown_count_mod_t_ff u_lo (
        .clk(clk), .rst(rst), .en(casc_en), .up_dn(1'b0), .load(1'b0),
        .load_val(4'd0), .wrap_clr(1'b0),
        .q(lo_q), .tc(lo_tc), .wrapped(lo_wrapped)
    );

    updown_count_mod_t_ff u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b0), .load(1'b0),
        .load_val(4'd0), .wrap_clr(1'b0),
        .q(hi_q), .tc(hi_tc), .wrapped(hi_wrapped)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] load_val;
        logic       wrap_clr;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic       exp_wrapped;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic r, input logic e, input logic u,
                              input logic l, input logic [3:0] lv, input logic wc,
                              input logic etc, input logic [3:0] eq, input logic ew);
        vec_t x;
        x.rst = r; x.en = e; x.up_dn = u; x.load = l; x.load_val = lv;
        x.wrap_clr = wc; x.exp_tc = etc; x.exp_q = eq; x.exp_wrapped = ew;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] model;

        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; wrap_clr = 1'b0; casc_en = 1'b0;

        //  rst en up ld lv  wc  tc  q  wr
        v(1, 0, 1, 0, 0,  0,  0, 0, 0);
        v(1, 0, 1, 0, 0,  0,  0, 0, 0);
        // count up through the modulus
        v(0, 1, 1, 0, 0,  0,  0, 1, 0);
        v(0, 1, 1, 0, 0,  0,  0, 2, 0);
        v(0, 1, 1, 0, 0,  0,  0, 3, 0);
        v(0, 1, 1, 0, 0,  0,  0, 4, 0);
        v(0, 1, 1, 0, 0,  0,  0, 5, 0);
        v(0, 1, 1, 0, 0,  0,  0, 6, 0);
        v(0, 1, 1, 0, 0,  0,  0, 7, 0);
        v(0, 1, 1, 0, 0,  0,  0, 8, 0);
        v(0, 1, 1, 0, 0,  0,  0, 9, 0);
        v(0, 1, 1, 0, 0,  0,  1, 0, 1);
        v(0, 1, 1, 0, 0,  0,  0, 1, 1);
        v(0, 1, 1, 0, 0,  0,  0, 2, 1);
        // load 3 then count down through zero
        v(0, 0, 1, 1, 3,  0,  0, 3, 1);
        v(0, 1, 0, 0, 0,  0,  0, 2, 1);
        v(0, 1, 0, 0, 0,  0,  0, 1, 1);
        v(0, 1, 0, 0, 0,  0,  0, 0, 1);
        v(0, 1, 0, 0, 0,  0,  1, 9, 1);
        v(0, 1, 0, 0, 0,  0,  0, 8, 1);
        // clamped loads and load-over-count priority
        v(0, 0, 0, 1, 14, 0,  0, 9, 1);
        v(0, 1, 1, 1, 5,  0,  0, 5, 1);
        v(0, 0, 0, 1, 10, 0,  0, 9, 1);
        v(0, 0, 0, 1, 5,  0,  0, 5, 1);
        // hold with direction toggling, then reset beating load
        v(0, 0, 1, 0, 0,  0,  0, 5, 1);
        v(0, 0, 0, 0, 0,  0,  0, 5, 1);
        v(0, 0, 1, 0, 0,  0,  0, 5, 1);
        v(0, 0, 0, 0, 0,  0,  0, 5, 1);
        v(1, 1, 1, 1, 7,  0,  0, 0, 0);
        // load at the wrap point does not set wrapped
        v(0, 0, 1, 1, 9,  0,  0, 9, 0);
        v(0, 1, 1, 1, 4,  0,  0, 4, 0);
        // wrap vs clear in the same cycle, then a plain clear
        v(0, 0, 1, 1, 9,  0,  0, 9, 0);
        v(0, 1, 1, 0, 0,  0,  1, 0, 1);
        v(0, 0, 1, 1, 9,  0,  0, 9, 1);
        v(0, 1, 1, 0, 0,  1,  1, 0, 1);
        v(0, 0, 1, 0, 0,  1,  0, 0, 0);
        // direction change mid-count
        v(0, 0, 0, 0, 0,  0,  0, 0, 0);
        v(0, 1, 1, 0, 0,  0,  0, 1, 0);
        v(0, 1, 0, 0, 0,  0,  0, 0, 0);
        v(0, 1, 0, 0, 0,  0,  1, 9, 1);
        v(0, 1, 0, 0, 0,  1,  0, 8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            en       = vecs[i].en;
            up_dn    = vecs[i].up_dn;
            load     = vecs[i].load;
            load_val = vecs[i].load_val;
            wrap_clr = vecs[i].wrap_clr;
            #1;
            check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].exp_wrapped));
        end

        // cascaded default-parameter pair: 8-bit down count from reset
        rst = 1'b1; en = 1'b0; load = 1'b0; wrap_clr = 1'b0; casc_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("casc_reset", 32'({hi_q, lo_q}), 32'd0);
        check("casc_tc_idle", 32'(lo_tc), 32'd0);
        model = 8'd0;
        casc_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            check($sformatf("casc%0d_lo_tc", c), 32'(lo_tc), 32'(model[3:0] == 4'd0));
            @(posedge clk);
            #1;
            model = model - 8'd1;
            check($sformatf("casc%0d_q", c), 32'({hi_q, lo_q}), 32'(model));
        end
        casc_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
